// File: rtl/rv_fifo_buffer.sv
// Ready/valid FIFO of DEPTH x WIDTH words with occupancy output; RV_FIFO_BYPASS_EN adds cut-through when empty.
// Latency: 1 cycle push-to-pop (0 cycles through the bypass path when enabled and level=0).
// Backpressure: in_a_ready drops at level=DEPTH; out_a_valid/out_a_data hold until popped.
module rv_fifo_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_a_data,
    input  logic                         in_a_valid,
    output logic                         in_a_ready,
    output logic [WIDTH-1:0]             out_a_data,
    output logic                         out_a_valid,
    input  logic                         out_a_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full, empty, push, pop, bypass;

    assign full       = (level_q == LW'(DEPTH));
    assign empty      = (level_q == '0);
    assign in_a_ready = ~full;
    assign level      = level_q;

`ifdef RV_FIFO_BYPASS_EN
    // When empty the input is presented directly; a word taken the same cycle never touches storage.
    assign out_a_valid = empty ? in_a_valid : 1'b1;
    assign out_a_data  = empty ? in_a_data : mem_q[rd_ptr_q];
    assign bypass      = empty & in_a_valid & out_a_ready;
`else
    assign out_a_valid = ~empty;
    assign out_a_data  = mem_q[rd_ptr_q];
    assign bypass      = 1'b0;
`endif

    assign push = in_a_valid & in_a_ready & ~bypass;
    assign pop  = ~empty & out_a_ready;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_a_data;
        end
    end

endmodule

// File: tb/tb_rv_fifo_buffer.sv
// Bench for rv_fifo_buffer: DEPTH=4 and DEPTH=3 instances checked by fixed tables, hand sequences and a queue model.
module tb_rv_fifo_buffer;

`ifdef RV_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;

    logic [7:0] a_idat, a_odat;
    logic       a_ivld, a_irdy, a_ovld, a_ordy;
    logic [2:0] a_level;

    logic [7:0] b_idat, b_odat;
    logic       b_ivld, b_irdy, b_ovld, b_ordy;
    logic [1:0] b_level;

    rv_fifo_buffer #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_a_data(a_idat), .in_a_valid(a_ivld), .in_a_ready(a_irdy),
        .out_a_data(a_odat), .out_a_valid(a_ovld), .out_a_ready(a_ordy),
        .level(a_level)
    );

    rv_fifo_buffer #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_a_data(b_idat), .in_a_valid(b_ivld), .in_a_ready(b_irdy),
        .out_a_data(b_odat), .out_a_valid(b_ovld), .out_a_ready(b_ordy),
        .level(b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_lv;
    } vec_t;

    vec_t       tbl [21];
    logic [7:0] mq [$];
    int         mdepth;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle on the chosen instance, compares against the queue model, then commits the edge.
    task automatic model_step(input int which, input logic iv, input logic [7:0] id, input logic ordy);
        logic       e_ir, e_ov, pass, push, pop;
        logic [7:0] e_od;
        int         e_lv;
        if (which == 4) begin a_ivld = iv; a_idat = id; a_ordy = ordy; end
        else            begin b_ivld = iv; b_idat = id; b_ordy = ordy; end
        @(negedge clk);
        e_lv = mq.size();
        e_ir = (e_lv != mdepth);
        e_ov = (e_lv != 0);
        e_od = e_ov ? mq[0] : 8'h00;
        pass = 1'b0;
        if (BYP && e_lv == 0) begin
            e_ov = iv;
            e_od = id;
            pass = iv & ordy;
        end
        if (which == 4) begin
            chk("m4_in_ready", int'(a_irdy), int'(e_ir));
            chk("m4_out_valid", int'(a_ovld), int'(e_ov));
            chk("m4_level", int'(a_level), e_lv);
            if (e_ov) chk("m4_out_data", int'(a_odat), int'(e_od));
        end else begin
            chk("m3_in_ready", int'(b_irdy), int'(e_ir));
            chk("m3_out_valid", int'(b_ovld), int'(e_ov));
            chk("m3_level", int'(b_level), e_lv);
            if (e_ov) chk("m3_out_data", int'(b_odat), int'(e_od));
        end
        pop  = (e_lv != 0) && ordy;
        push = iv && e_ir && !pass;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(id);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, BYP,  8'h01, 0};
        tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1};
        tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 2};
        tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3};
        tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 4};
        tbl[5]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 4};
        tbl[6]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01, 4};
        tbl[7]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 3};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 3};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[12] = '{1'b1, 8'hAA, 1'b0, 1'b1, BYP,  8'hAA, 0};
        tbl[13] = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 8'hAA, 1};
        for (int i = 14; i < 18; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hAA, 2};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hAA, 2};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hBB, 1};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

        rst_n = 1'b0;
        a_ivld = 1'b0; a_idat = 8'h00; a_ordy = 1'b0;
        b_ivld = 1'b0; b_idat = 8'h00; b_ordy = 1'b0;
        mdepth = 4;

        repeat (2) @(negedge clk);
        chk("rst_level", int'(a_level), 0);
        chk("rst_out_valid", int'(a_ovld), 0);
        chk("rst_in_ready", int'(a_irdy), 1);
        chk("rst3_level", int'(b_level), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill to full, drain in order, then hold under back-pressure.
        for (int i = 0; i < 21; i++) begin
            a_ivld = tbl[i].iv; a_idat = tbl[i].id; a_ordy = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), int'(a_irdy), int'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), int'(a_ovld), int'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_level", i), int'(a_level), tbl[i].e_lv);
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), int'(a_odat), int'(tbl[i].e_od));
            @(posedge clk); #1;
        end

        // Asynchronous reset with three words buffered.
        mq.delete();
        model_step(4, 1'b1, 8'h11, 1'b0);
        model_step(4, 1'b1, 8'h22, 1'b0);
        model_step(4, 1'b1, 8'h33, 1'b0);
        a_ivld = 1'b0;
        #2;
        chk("pre_rst_level", int'(a_level), 3);
        rst_n = 1'b0;
        #1;
        chk("arst_level", int'(a_level), 0);
        chk("arst_out_valid", int'(a_ovld), 0);
        chk("arst_in_ready", int'(a_irdy), 1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_step(4, 1'b1, 8'h5A, 1'b0);
        a_ivld = 1'b0;
        @(negedge clk);
        chk("post_rst_first", int'(a_odat), 8'h5A);
        @(posedge clk); #1;
        model_step(4, 1'b0, 8'h00, 1'b1);

        // Zero-latency versus one-cycle presentation from empty.
        a_ivld = 1'b1; a_idat = 8'h3C; a_ordy = 1'b1;
        @(negedge clk);
        chk("byp_c0_out_valid", int'(a_ovld), int'(BYP));
        if (BYP) chk("byp_c0_out_data", int'(a_odat), 8'h3C);
        chk("byp_c0_level", int'(a_level), 0);
        @(posedge clk); #1;
        a_ivld = 1'b0; a_idat = 8'h00;
        @(negedge clk);
        chk("byp_c1_out_valid", int'(a_ovld), int'(!BYP));
        if (!BYP) chk("byp_c1_out_data", int'(a_odat), 8'h3C);
        chk("byp_c1_level", int'(a_level), BYP ? 0 : 1);
        @(posedge clk); #1;
        chk("byp_c2_level", int'(a_level), 0);

        // Streaming: steady one transfer per cycle.
        for (int i = 0; i < 100; i++) model_step(4, 1'b1, 8'(i + 1), 1'b1);
        chk("stream_level", int'(a_level), BYP ? 0 : 1);
        model_step(4, 1'b0, 8'h00, 1'b1);
        model_step(4, 1'b0, 8'h00, 1'b1);

        // Random stalls on the DEPTH=3 instance exercise pointer wrap.
        a_ivld = 1'b0; a_ordy = 1'b0;
        mq.delete();
        mdepth = 3;
        for (int i = 0; i < 300; i++) begin
            model_step(3, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0 ? (i % 40 < 20) : 1));
        end
        for (int i = 0; i < 4; i++) model_step(3, 1'b0, 8'h00, 1'b1);
        chk("rand_drained", int'(b_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
